// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register and drives a
// variable-latency req/ack instruction-memory port under controller stall/flush.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [5:0]            stall_in,
    input  logic                  flush_jump_in,
    input  logic [ADDR_WIDTH-1:0] new_pc_in,
    output logic                  imem_req_out,
    output logic [ADDR_WIDTH-1:0] imem_addr_out,
    input  logic                  imem_ack_in,
    input  logic [DATA_WIDTH-1:0] imem_data_in,
    output logic                  stallreq_from_if_out,
    output logic [ADDR_WIDTH-1:0] if_pc_out,
    output logic [DATA_WIDTH-1:0] if_inst_out,
    output logic                  if_valid_out
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [DATA_WIDTH-1:0] if_inst_q, if_inst_d;
    logic                  if_valid_q, if_valid_d;

    logic                  hold;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  unused_stall;

    assign hold         = stall_in[0] | stall_in[1];
    assign pc_plus4     = pc_q + ADDR_WIDTH'(4);
    assign unused_stall = ^stall_in[5:2];

    // Flush always wins over hold; in DROP the pending target tracks the newest flush.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        buf_d      = buf_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;

        unique case (state_q)
            S_REQ: begin
                if (imem_ack_in) begin
                    if (flush_jump_in) begin
                        pc_d       = new_pc_in;
                        if_valid_d = 1'b0;
                    end else if (!hold) begin
                        if_pc_d    = pc_q;
                        if_inst_d  = imem_data_in;
                        if_valid_d = 1'b1;
                        pc_d       = pc_plus4;
                    end else begin
                        buf_d   = imem_data_in;
                        state_d = S_HOLD;
                    end
                end else begin
                    if (flush_jump_in) begin
                        pend_pc_d  = new_pc_in;
                        if_valid_d = 1'b0;
                        state_d    = S_DROP;
                    end else if (!hold) begin
                        if_valid_d = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                if (flush_jump_in) begin
                    pc_d       = new_pc_in;
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end else if (!hold) begin
                    if_pc_d    = pc_q;
                    if_inst_d  = buf_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_plus4;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                if (flush_jump_in) begin
                    if_valid_d = 1'b0;
                end
                if (imem_ack_in) begin
                    pc_d    = flush_jump_in ? new_pc_in : pend_pc_q;
                    state_d = S_REQ;
                end else if (flush_jump_in) begin
                    pend_pc_d = new_pc_in;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    // Buffer and pending target are only read in the states that wrote them.
    always_ff @(posedge clk_in) begin
        pend_pc_q <= pend_pc_d;
        buf_q     <= buf_d;
    end

    // pc_q is not advanced while DROP waits, so it is still the squashed address.
    assign imem_req_out         = !reset_in && (state_q == S_REQ || state_q == S_DROP);
    assign imem_addr_out        = pc_q;
    assign stallreq_from_if_out = !reset_in && (state_q == S_REQ) && !imem_ack_in && !flush_jump_in;

    assign if_pc_out    = if_pc_q;
    assign if_inst_out  = if_inst_q;
    assign if_valid_out = if_valid_q;

endmodule
